// File: rtl/mem_port_arbiter_if.sv
// Core-side (imem/dmem) and memory-side signal bundle for mem_port_arbiter.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with one pending slot per port, one outstanding command, and a per-wait watchdog.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              proto_err,
    output logic              timeout_err
);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_I = 2'd2,
        ST_WAIT_D = 2'd3
    } state_t;

    state_t      state_r;
    logic        i_vld_r;
    logic [31:0] i_addr_r;
    logic [3:0]  i_rmask_r;
    logic        d_vld_r;
    logic [31:0] d_addr_r;
    logic [3:0]  d_rmask_r;
    logic [3:0]  d_wmask_r;
    logic [31:0] d_wdata_r;
    logic        last_grant_r;   // 1 = D port held the most recent grant
    logic        cmd_store_r;
    logic [15:0] wd_cnt_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_rmask_r;
    logic [3:0]  mem_wmask_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] imem_rdata_r;
    logic        imem_resp_r;
    logic [31:0] dmem_rdata_r;
    logic        dmem_resp_r;
    logic        proto_err_r;
    logic        timeout_err_r;

    logic        i_req_s;
    logic        d_req_s;
    logic        d_both_s;
    logic        i_drop_s;
    logic        d_drop_s;
    logic        any_vld_s;
    logic        grant_d_s;
    logic        wd_expire_s;
    logic [31:0] rsp_data_s;

    // Request decode, drop detection, grant selection and response data selection
    always_comb begin
        i_req_s     = (bus.imem_rmask != 4'h0);
        d_req_s     = (bus.dmem_rmask != 4'h0) || (bus.dmem_wmask != 4'h0);
        d_both_s    = (bus.dmem_rmask != 4'h0) && (bus.dmem_wmask != 4'h0);
        i_drop_s    = i_req_s && (i_vld_r || (state_r == ST_WAIT_I));
        d_drop_s    = d_req_s && (d_vld_r || (state_r == ST_WAIT_D));
        any_vld_s   = i_vld_r || d_vld_r;
        grant_d_s   = d_vld_r && (!i_vld_r || !last_grant_r);
        wd_expire_s = (wd_cnt_r == WD_LAST);
        rsp_data_s  = (bus.mem_resp && !cmd_store_r) ? bus.mem_rdata : 32'h0000_0000;
    end

    // Pending slots and the sticky protocol-violation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_vld_r     <= 1'b0;
            i_addr_r    <= 32'h0000_0000;
            i_rmask_r   <= 4'h0;
            d_vld_r     <= 1'b0;
            d_addr_r    <= 32'h0000_0000;
            d_rmask_r   <= 4'h0;
            d_wmask_r   <= 4'h0;
            d_wdata_r   <= 32'h0000_0000;
            proto_err_r <= 1'b0;
        end else begin
            // A dropped request implies the slot is still occupied, so load and grant never collide
            if (i_req_s && !i_drop_s) begin
                i_vld_r   <= 1'b1;
                i_addr_r  <= bus.imem_addr & 32'hFFFF_FFFC;
                i_rmask_r <= bus.imem_rmask;
            end else if ((state_r == ST_IDLE) && any_vld_s && !grant_d_s) begin
                i_vld_r <= 1'b0;
            end

            if (d_req_s && !d_drop_s) begin
                d_vld_r   <= 1'b1;
                d_addr_r  <= bus.dmem_addr & 32'hFFFF_FFFC;
                d_rmask_r <= d_both_s ? 4'h0 : bus.dmem_rmask;
                d_wmask_r <= bus.dmem_wmask;
                d_wdata_r <= bus.dmem_wdata;
            end else if ((state_r == ST_IDLE) && grant_d_s) begin
                d_vld_r <= 1'b0;
            end

            if (i_drop_s || d_drop_s || d_both_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Command FSM: grant, single-cycle issue, wait with watchdog, response return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b1;
            cmd_store_r   <= 1'b0;
            wd_cnt_r      <= 16'h0000;
            mem_addr_r    <= 32'h0000_0000;
            mem_rmask_r   <= 4'h0;
            mem_wmask_r   <= 4'h0;
            mem_wdata_r   <= 32'h0000_0000;
            imem_rdata_r  <= 32'h0000_0000;
            imem_resp_r   <= 1'b0;
            dmem_rdata_r  <= 32'h0000_0000;
            dmem_resp_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            imem_resp_r <= 1'b0;
            dmem_resp_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_vld_s) begin
                        state_r      <= ST_ISSUE;
                        last_grant_r <= grant_d_s;
                        if (grant_d_s) begin
                            mem_addr_r  <= d_addr_r;
                            mem_rmask_r <= d_rmask_r;
                            mem_wmask_r <= d_wmask_r;
                            mem_wdata_r <= d_wdata_r;
                            cmd_store_r <= (d_wmask_r != 4'h0);
                        end else begin
                            mem_addr_r  <= i_addr_r;
                            mem_rmask_r <= i_rmask_r;
                            mem_wmask_r <= 4'h0;
                            mem_wdata_r <= 32'h0000_0000;
                            cmd_store_r <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_rmask_r <= 4'h0;
                    mem_wmask_r <= 4'h0;
                    wd_cnt_r    <= 16'h0000;
                    state_r     <= last_grant_r ? ST_WAIT_D : ST_WAIT_I;
                end
                ST_WAIT_I, ST_WAIT_D: begin
                    // A response in the expiry cycle still wins over the watchdog
                    if (bus.mem_resp || wd_expire_s) begin
                        if (state_r == ST_WAIT_D) begin
                            dmem_resp_r  <= 1'b1;
                            dmem_rdata_r <= rsp_data_s;
                        end else begin
                            imem_resp_r  <= 1'b1;
                            imem_rdata_r <= rsp_data_s;
                        end
                        if (!bus.mem_resp) begin
                            timeout_err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'h0001;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_rmask  = mem_rmask_r;
    assign bus.mem_wmask  = mem_wmask_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.imem_rdata = imem_rdata_r;
    assign bus.imem_resp  = imem_resp_r;
    assign bus.dmem_rdata = dmem_rdata_r;
    assign bus.dmem_resp  = dmem_resp_r;
    assign busy           = (state_r != ST_IDLE) || any_vld_s;
    assign proto_err      = proto_err_r;
    assign timeout_err    = timeout_err_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level
// reference model built from cycle stamps (grant cycle, command cycle, response cycle).
module tb_mem_port_arbiter;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, proto_err, timeout_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          cyc;
    bit          sv [2];
    logic [31:0] sa [2];
    logic [3:0]  srm [2];
    logic [3:0]  swm [2];
    logic [31:0] swd [2];
    bit          infl;
    int          owner, last_g;
    int          cmd_c, resp_c, end_c;
    bit          m_to;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_rm, m_wm;
    bit          exp_pe, exp_te;

    // stimulus knobs
    int          lat_force;
    bit          use_fixed;
    logic [31:0] fixed_rd;
    bit          spur_en, force_resp;
    bit          fair_mode, have_prev, prev_port;
    int          ni_obs, nd_obs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_model();
        cyc = 0; infl = 1'b0; last_g = 1; owner = 0;
        cmd_c = -10; resp_c = -1; end_c = -10; m_to = 1'b0;
        exp_pe = 1'b0; exp_te = 1'b0;
        for (int p = 0; p < 2; p++) sv[p] = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, ".mem_addr"},   bus.mem_addr, 32'h0);
        check_eq({tag, ".mem_rmask"},  32'(bus.mem_rmask), 32'h0);
        check_eq({tag, ".mem_wmask"},  32'(bus.mem_wmask), 32'h0);
        check_eq({tag, ".mem_wdata"},  bus.mem_wdata, 32'h0);
        check_eq({tag, ".imem_rdata"}, bus.imem_rdata, 32'h0);
        check_eq({tag, ".imem_resp"},  32'(bus.imem_resp), 32'h0);
        check_eq({tag, ".dmem_rdata"}, bus.dmem_rdata, 32'h0);
        check_eq({tag, ".dmem_resp"},  32'(bus.dmem_resp), 32'h0);
        check_eq({tag, ".busy"},       32'(busy), 32'h0);
        check_eq({tag, ".proto_err"},  32'(proto_err), 32'h0);
        check_eq({tag, ".timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic [3:0] irm, input logic [31:0] ia,
                        input logic [3:0] drm, input logic [3:0] dwm,
                        input logic [31:0] da, input logic [31:0] dwd);
        bit win, cur, ir, dr, idrop, ddrop, dreq, port_obs;
        logic [31:0] exp_rd;
        int g, lat;
        bus.imem_rmask = irm; bus.imem_addr = ia;
        bus.dmem_rmask = drm; bus.dmem_wmask = dwm;
        bus.dmem_addr = da;   bus.dmem_wdata = dwd;
        win = infl && (cyc > cmd_c) && (cyc < end_c);
        if (win) begin
            bus.mem_resp  = (cyc == resp_c);
            bus.mem_rdata = (cyc == resp_c) ? m_rd : $urandom;
        end else begin
            bus.mem_resp  = force_resp || (spur_en && ($urandom_range(0, 4) == 0));
            bus.mem_rdata = $urandom;
        end

        @(negedge clk);
        cur = infl && (cyc == cmd_c);
        check_eq("mem_rmask", 32'(bus.mem_rmask), cur ? 32'(m_rm) : 32'h0);
        check_eq("mem_wmask", 32'(bus.mem_wmask), cur ? 32'(m_wm) : 32'h0);
        if (cur) begin
            check_eq("mem_addr", bus.mem_addr, m_addr);
            if (m_wm != 4'h0) check_eq("mem_wdata", bus.mem_wdata, m_wd);
        end
        ir = infl && (cyc == end_c) && (owner == 0);
        dr = infl && (cyc == end_c) && (owner == 1);
        exp_rd = (m_to || (m_wm != 4'h0)) ? 32'h0 : m_rd;
        check_eq("imem_resp", 32'(bus.imem_resp), 32'(ir));
        check_eq("dmem_resp", 32'(bus.dmem_resp), 32'(dr));
        if (ir) check_eq("imem_rdata", bus.imem_rdata, exp_rd);
        if (dr) check_eq("dmem_rdata", bus.dmem_rdata, exp_rd);
        check_eq("busy", 32'(busy), 32'((infl && cyc >= cmd_c && cyc < end_c) || sv[0] || sv[1]));
        check_eq("proto_err", 32'(proto_err), 32'(exp_pe));
        check_eq("timeout_err", 32'(timeout_err), 32'(exp_te));
        if (fair_mode) begin
            if ((bus.mem_rmask != 4'h0) || (bus.mem_wmask != 4'h0)) begin
                port_obs = (bus.mem_wmask != 4'h0);
                if (have_prev) check_eq("fair_alternate", 32'(port_obs != prev_port), 32'h1);
                prev_port = port_obs; have_prev = 1'b1;
            end
            if (bus.imem_resp) ni_obs++;
            if (bus.dmem_resp) nd_obs++;
            if (bus.imem_resp || bus.dmem_resp)
                check_eq("fair_lead", 32'((ni_obs > nd_obs + 1) || (nd_obs > ni_obs + 1)), 32'h0);
        end

        // model update for the next cycle
        dreq  = (drm != 4'h0) || (dwm != 4'h0);
        idrop = (irm != 4'h0) && (sv[0] || (infl && owner == 0 && cyc > cmd_c && cyc < end_c));
        ddrop = dreq && (sv[1] || (infl && owner == 1 && cyc > cmd_c && cyc < end_c));
        if (idrop || ddrop || ((drm != 4'h0) && (dwm != 4'h0))) exp_pe = 1'b1;
        if (infl && m_to && (cyc == end_c - 1)) exp_te = 1'b1;
        if ((!infl || cyc >= end_c) && (sv[0] || sv[1])) begin
            g = (sv[0] && sv[1]) ? ((last_g == 1) ? 0 : 1) : (sv[1] ? 1 : 0);
            last_g = g; owner = g; infl = 1'b1; cmd_c = cyc + 1;
            m_addr = sa[g]; m_rm = srm[g]; m_wm = swm[g]; m_wd = swd[g];
            sv[g] = 1'b0;
            lat  = (lat_force > 0) ? lat_force : $urandom_range(1, T + 2);
            m_rd = use_fixed ? fixed_rd : $urandom;
            if (lat <= T) begin
                m_to = 1'b0; resp_c = cmd_c + lat; end_c = resp_c + 1;
            end else begin
                m_to = 1'b1; resp_c = -1; end_c = cmd_c + T + 1;
            end
        end else if (infl && cyc >= end_c) begin
            infl = 1'b0;
        end
        if ((irm != 4'h0) && !idrop) begin
            sv[0] = 1'b1; sa[0] = ia & 32'hFFFF_FFFC; srm[0] = irm; swm[0] = 4'h0; swd[0] = 32'h0;
        end
        if (dreq && !ddrop) begin
            sv[1] = 1'b1; sa[1] = da & 32'hFFFF_FFFC;
            srm[1] = (dwm != 4'h0) ? 4'h0 : drm; swm[1] = dwm; swd[1] = dwd;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit ri, rdq;
        logic [3:0] irm, drm, dwm;
        int kind;
        bus.imem_addr = 32'h0; bus.imem_rmask = 4'h0;
        bus.dmem_addr = 32'h0; bus.dmem_rmask = 4'h0; bus.dmem_wmask = 4'h0; bus.dmem_wdata = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_resp = 1'b0;
        lat_force = 0; use_fixed = 1'b0; fixed_rd = 32'h0;
        spur_en = 1'b0; force_resp = 1'b0; fair_mode = 1'b0; have_prev = 1'b0; prev_port = 1'b0;
        ni_obs = 0; nd_obs = 0;
        reset_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();

        // single fetch with fixed data, minimum latency
        lat_force = 1; use_fixed = 1'b1; fixed_rd = 32'hDEAD_BEEF;
        step(4'hF, 32'h6000_0003, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(6);
        use_fixed = 1'b0;

        // simultaneous I load and D store, then a second tie
        lat_force = 2;
        step(4'hF, $urandom, 4'h0, 4'h3, $urandom, 32'h0000_1234);
        idle(12);
        step(4'h3, $urandom, 4'hF, 4'h0, $urandom, $urandom);
        idle(12);

        // contention fairness: both ports re-request on every response
        lat_force = 3; fair_mode = 1'b1;
        step(4'hF, $urandom, 4'h0, 4'hF, $urandom, $urandom);
        for (int k = 0; k < 200 && (ni_obs + nd_obs) < 10; k++) begin
            ri  = infl && (cyc == end_c) && (owner == 0);
            rdq = infl && (cyc == end_c) && (owner == 1);
            step(ri ? 4'hF : 4'h0, $urandom, 4'h0, rdq ? 4'hF : 4'h0, $urandom, $urandom);
        end
        check_eq("fair_done", 32'((ni_obs + nd_obs) >= 10), 32'h1);
        idle(14);
        fair_mode = 1'b0;

        // watchdog timeout on a D load, then late responses in IDLE
        lat_force = 99;
        step(4'h0, 32'h0, 4'hF, 4'h0, 32'h1000_0008, 32'h0);
        idle(8);
        force_resp = 1'b1;
        idle(3);
        force_resp = 1'b0;

        // protocol errors: duplicate fetch, then load+store masks together
        lat_force = 2;
        step(4'hF, 32'h2000_0004, 4'h0, 4'h0, 32'h0, 32'h0);
        step(4'hF, 32'h2000_0008, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(8);
        step(4'h0, 32'h0, 4'hF, 4'hF, 32'h3000_0010, 32'hCAFE_F00D);
        idle(8);

        // randomized traffic with spurious responses and random latencies
        lat_force = 0; spur_en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            irm  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            kind = $urandom_range(0, 11);
            drm  = (kind <= 1 || kind == 4) ? 4'($urandom_range(1, 15)) : 4'h0;
            dwm  = (kind == 2 || kind == 3 || kind == 4) ? 4'($urandom_range(1, 15)) : 4'h0;
            step(irm, $urandom, drm, dwm, $urandom, $urandom);
        end
        spur_en = 1'b0;
        idle(25);

        // reset while waiting on a D load
        lat_force = 99;
        step(4'h0, 32'h0, 4'hF, 4'h0, 32'h4000_0000, 32'h0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_reset_zero("reset_mid_wait");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        force_resp = 1'b1;
        idle(4);
        force_resp = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
